// File: rtl/branch_sequencer.sv
// Branch/jump resolution sequencer: captures in ID, resolves in EX, redirects and flushes from MEM.
// Optional statistics counters are enabled by defining BRANCH_STATS_EN.
module branch_sequencer (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [1:0]  ID_BrType,
  input  logic [31:0] ID_PCPlus4,
  input  logic [31:0] ID_Imm,
  input  logic [25:0] ID_JIdx,
  input  logic        Stall,
  input  logic        EX_Zero,
  output logic        Redirect,
  output logic [31:0] TargetPC,
  output logic        Flush_IF_ID,
  output logic        Flush_ID_EX,
  output logic        Flush_EX_MEM,
  output logic        Busy,
  output logic [31:0] BranchCount,
  output logic [31:0] TakenCount
);

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_J    = 2'b11
  } br_t;

  br_t         id_type;
  br_t         ex_type;
  logic        ex_valid;
  logic [31:0] ex_target;
  logic        ex_taken;
  logic        mem_valid;
  logic        mem_taken;
  logic [31:0] mem_target;
  logic [31:0] id_target;
  logic        unused_imm_hi;

  assign id_type       = br_t'(ID_BrType);
  // Offset bits 31:30 are shifted out of the word-to-byte conversion.
  assign unused_imm_hi = ^ID_Imm[31:30];

  always_comb begin
    id_target = ID_PCPlus4 + {ID_Imm[29:0], 2'b00};
    if (id_type == BR_J)
      id_target = {ID_PCPlus4[31:28], ID_JIdx, 2'b00};
  end

  always_comb begin
    ex_taken = 1'b0;
    case (ex_type)
      BR_BEQ:  ex_taken = EX_Zero;
      BR_BNE:  ex_taken = ~EX_Zero;
      BR_J:    ex_taken = 1'b1;
      default: ex_taken = 1'b0;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ex_valid   <= 1'b0;
      ex_type    <= BR_NONE;
      ex_target  <= '0;
      mem_valid  <= 1'b0;
      mem_taken  <= 1'b0;
      mem_target <= '0;
    end else if (Redirect) begin
      ex_valid  <= 1'b0;
      mem_valid <= 1'b0;
    end else begin
      // MEM advances on both the stall and normal paths; only EX differs.
      mem_valid  <= ex_valid;
      mem_taken  <= ex_taken;
      mem_target <= ex_target;
      if (Stall) begin
        ex_valid <= 1'b0;
      end else begin
        ex_valid  <= (id_type != BR_NONE);
        ex_type   <= id_type;
        ex_target <= id_target;
      end
    end
  end

  assign Redirect     = mem_valid & mem_taken;
  assign TargetPC     = mem_valid ? mem_target : '0;
  assign Flush_IF_ID  = Redirect;
  assign Flush_ID_EX  = Redirect;
  assign Flush_EX_MEM = Redirect;
  assign Busy         = ex_valid | mem_valid;

`ifdef BRANCH_STATS_EN
  logic [31:0] branch_cnt;
  logic [31:0] taken_cnt;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else begin
      if (mem_valid) branch_cnt <= branch_cnt + 32'd1;
      if (Redirect)  taken_cnt  <= taken_cnt + 32'd1;
    end
  end

  assign BranchCount = branch_cnt;
  assign TakenCount  = taken_cnt;
`else
  assign BranchCount = '0;
  assign TakenCount  = '0;
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Scoreboard bench for branch_sequencer: an in-flight instruction list predicts each cycle's outputs.
module tb_branch_sequencer;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [1:0]  ID_BrType = '0;
  logic [31:0] ID_PCPlus4 = '0;
  logic [31:0] ID_Imm = '0;
  logic [25:0] ID_JIdx = '0;
  logic        Stall = 1'b0;
  logic        EX_Zero = 1'b0;
  logic        Redirect;
  logic [31:0] TargetPC;
  logic        Flush_IF_ID, Flush_ID_EX, Flush_EX_MEM;
  logic        Busy;
  logic [31:0] BranchCount, TakenCount;

  branch_sequencer dut (
    .Clk(Clk), .Rst(Rst), .ID_BrType(ID_BrType), .ID_PCPlus4(ID_PCPlus4),
    .ID_Imm(ID_Imm), .ID_JIdx(ID_JIdx), .Stall(Stall), .EX_Zero(EX_Zero),
    .Redirect(Redirect), .TargetPC(TargetPC), .Flush_IF_ID(Flush_IF_ID),
    .Flush_ID_EX(Flush_ID_EX), .Flush_EX_MEM(Flush_EX_MEM), .Busy(Busy),
    .BranchCount(BranchCount), .TakenCount(TakenCount)
  );

  always #5 Clk = ~Clk;

  // An instruction issued from ID in cycle "issue" sits in EX at issue+1 and MEM at issue+2.
  typedef struct {
    int          issue;
    logic [1:0]  typ;
    logic [31:0] tgt;
    bit          taken;
  } rec_t;

  typedef struct {
    logic        redir;
    logic [31:0] tgt;
    logic        busy;
    logic [31:0] bc;
    logic [31:0] tc;
  } exp_t;

  rec_t        fl[$];
  exp_t        sb[$];
  int          cyc_n = 0;
  logic [31:0] m_bc = '0;
  logic [31:0] m_tc = '0;
  int          total = 0;
  int          passed = 0;
  int          redirects_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc_n, act, exp);
  endtask

  function automatic bit taken_rule(input logic [1:0] typ, input bit zero);
    if (typ == 2'b01) return zero;
    if (typ == 2'b10) return !zero;
    return typ == 2'b11;
  endfunction

  function automatic logic [31:0] target_of(input logic [1:0] typ, input logic [31:0] pc,
                                            input logic [31:0] imm, input logic [25:0] jidx);
    logic [31:0] j;
    j = {6'd0, jidx};
    if (typ == 2'b11) return (pc & 32'hF000_0000) | (j * 32'd4);
    return pc + imm * 32'd4;
  endfunction

  task automatic step(input bit rst, input logic [1:0] typ, input logic [31:0] pc,
                      input logic [31:0] imm, input logic [25:0] jidx,
                      input bit stall, input bit zero);
    exp_t e;
    rec_t r;
    int   mi;
    int   ei;
    @(posedge Clk);
    #1;
    mi = -1;
    ei = -1;
    foreach (fl[i]) begin
      if (fl[i].issue == cyc_n - 2) mi = i;
      if (fl[i].issue == cyc_n - 1) ei = i;
    end
    e.redir = (mi >= 0) && fl[mi].taken;
    e.tgt   = (mi >= 0) ? fl[mi].tgt : 32'd0;
    e.busy  = (mi >= 0) || (ei >= 0);
`ifdef BRANCH_STATS_EN
    e.bc = m_bc;
    e.tc = m_tc;
`else
    e.bc = '0;
    e.tc = '0;
`endif
    if (rst) e = '{1'b0, 32'd0, 1'b0, 32'd0, 32'd0};
    sb.push_back(e);

    Rst        = !rst;
    ID_BrType  = typ;
    ID_PCPlus4 = pc;
    ID_Imm     = imm;
    ID_JIdx    = jidx;
    Stall      = stall;
    EX_Zero    = zero;

    if (rst) begin
      fl.delete();
      m_bc = '0;
      m_tc = '0;
    end else begin
      if (mi >= 0) m_bc = m_bc + 32'd1;
      if (e.redir) m_tc = m_tc + 32'd1;
      if (e.redir) begin
        fl.delete();
      end else begin
        if (ei >= 0) fl[ei].taken = taken_rule(fl[ei].typ, zero);
        if (mi >= 0) fl.delete(mi);
        if (!stall && typ != 2'b00) begin
          r.issue = cyc_n;
          r.typ   = typ;
          r.tgt   = target_of(typ, pc, imm, jidx);
          r.taken = 1'b0;
          fl.push_back(r);
        end
      end
    end
    cyc_n++;
  endtask

  task automatic idle(input int n, input bit zero);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 32'd0, 32'd0, 26'd0, 1'b0, zero);
  endtask

  always @(negedge Clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("Redirect", {31'd0, Redirect}, {31'd0, e.redir});
      chk("TargetPC", TargetPC, e.tgt);
      chk("Flushes", {29'd0, Flush_IF_ID, Flush_ID_EX, Flush_EX_MEM}, {29'd0, {3{e.redir}}});
      chk("Busy", {31'd0, Busy}, {31'd0, e.busy});
      chk("BranchCount", BranchCount, e.bc);
      chk("TakenCount", TakenCount, e.tc);
      if (Redirect === 1'b1) redirects_seen++;
    end
  end

  initial begin
    int snap;
    for (int i = 0; i < 3; i++) step(1'b1, 2'b00, 32'd0, 32'd0, 26'd0, 1'b0, 1'b0);
    idle(2, 1'b0);

    // reset while a BEQ is in flight
    step(1'b0, 2'b01, 32'h0000_0104, 32'd3, 26'd0, 1'b0, 1'b0);
    step(1'b1, 2'b00, 32'd0, 32'd0, 26'd0, 1'b0, 1'b1);
    idle(3, 1'b1);

    // BEQ taken -> 0x110
    snap = redirects_seen;
    step(1'b0, 2'b01, 32'h0000_0104, 32'd3, 26'd0, 1'b0, 1'b0);
    step(1'b0, 2'b00, 32'd0, 32'd0, 26'd0, 1'b0, 1'b1);
    idle(3, 1'b0);
    chk("BEQ taken redirect count", redirects_seen - snap, 1);

    // BNE backward with wrap, taken then not taken
    step(1'b0, 2'b10, 32'h0000_0004, 32'hFFFF_FFFE, 26'd0, 1'b0, 1'b1);
    step(1'b0, 2'b00, 32'd0, 32'd0, 26'd0, 1'b0, 1'b0);
    idle(3, 1'b0);
    snap = redirects_seen;
    step(1'b0, 2'b10, 32'h0000_0004, 32'hFFFF_FFFE, 26'd0, 1'b0, 1'b0);
    step(1'b0, 2'b00, 32'd0, 32'd0, 26'd0, 1'b0, 1'b1);
    idle(3, 1'b0);
    chk("BNE not taken redirect count", redirects_seen - snap, 0);

    // J regardless of zero flag
    step(1'b0, 2'b11, 32'h4000_0008, 32'd0, 26'h40, 1'b0, 1'b0);
    step(1'b0, 2'b00, 32'd0, 32'd0, 26'd0, 1'b0, 1'b1);
    idle(3, 1'b0);

    // taken BEQ then J: exactly one redirect
    step(1'b1, 2'b00, 32'd0, 32'd0, 26'd0, 1'b0, 1'b0);
    snap = redirects_seen;
    step(1'b0, 2'b01, 32'h0000_0104, 32'd3, 26'd0, 1'b0, 1'b0);
    step(1'b0, 2'b11, 32'h4000_0008, 32'd0, 26'h40, 1'b0, 1'b1);
    idle(4, 1'b0);
    chk("BEQ+J redirect count", redirects_seen - snap, 1);

    // stalled BEQ held in ID, then re-issued
    step(1'b0, 2'b01, 32'h0000_0104, 32'd3, 26'd0, 1'b1, 1'b0);
    step(1'b0, 2'b01, 32'h0000_0104, 32'd3, 26'd0, 1'b0, 1'b1);
    step(1'b0, 2'b00, 32'd0, 32'd0, 26'd0, 1'b1, 1'b1);
    idle(3, 1'b0);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] imm;
      imm = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom_range(0, 64) - 32);
      step($urandom_range(0, 59) == 0, 2'($urandom_range(0, 3)), $urandom, imm,
           26'($urandom), $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)));
    end
    idle(3, 1'b0);

    @(negedge Clk);
    #1;
    chk("scoreboard drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
